hamming_secded_dec: RTL and testbench

- Parametrised, pipelined Hamming decoder. Successor to the fixed (15,11) combinational encoder.
- Accepts codewords in the same bit layout the encoder produces and computes the syndrome. Corrects single-bit errors; with the optional feature it also detects double-bit errors.
- Streams data out over a valid/ready handshake and keeps saturating error-statistics counters.
- Sits between the channel/storage model and the data consumer.

---
 rtl/hamming_secded_dec.sv | 170 +++++++++++++++++
 tb/tb_hamming_secded_dec.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined Hamming decoder with single-error correction and saturating error counters.
// Define HAMMING_SECDED_EN to add the overall parity bit for double-error detection.
module hamming_secded_dec #(
  parameter int R     = 4,
  parameter int CNT_W = 16,
  localparam int N    = (1 << R) - 1,
  localparam int K    = N - R,
`ifdef HAMMING_SECDED_EN
  localparam int CW   = N + 1
`else
  localparam int CW   = N
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic [R-1:0]     out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorr
);

  function automatic logic [R-1:0] syndrome(input logic [N-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int p = 1; p <= N; p++) begin
      if (c[p-1]) s = s ^ R'(p);
    end
    return s;
  endfunction

  // Data bits occupy every non-power-of-two position, lowest position first.
  function automatic logic [K-1:0] extract(input logic [N-1:0] c);
    logic [K-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction

  logic             s1_valid_q;
  logic [N-1:0]     s1_code_q;
  logic [R-1:0]     s1_syn_q;
  logic             s2_valid_q;
  logic [K-1:0]     data_q;
  logic [R-1:0]     syn_q;
  logic             corr_q;
  logic [CNT_W-1:0] cnt_corr_q;
  logic             s2_adv;
  logic             xfer;
  logic             flip_en;
  logic             corr_d;
  logic [N-1:0]     flip_mask;
  logic [K-1:0]     data_d;
`ifdef HAMMING_SECDED_EN
  logic             s1_par_q;
  logic             unc_q;
  logic             unc_d;
  logic [CNT_W-1:0] cnt_unc_q;
`endif

  assign s2_adv   = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_adv;
  assign xfer     = s2_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
`ifdef HAMMING_SECDED_EN
      s1_par_q   <= 1'b0;
`endif
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_ready && in_valid) begin
        s1_code_q <= in_code[N-1:0];
        s1_syn_q  <= syndrome(in_code[N-1:0]);
`ifdef HAMMING_SECDED_EN
        s1_par_q  <= ^in_code;
`endif
      end
    end
  end

  always_comb begin
    flip_mask = '0;
`ifdef HAMMING_SECDED_EN
    // Odd overall parity means a single error; syn=0 then points at the overall bit itself.
    corr_d  = s1_par_q;
    unc_d   = !s1_par_q && (s1_syn_q != '0);
    flip_en = s1_par_q && (s1_syn_q != '0);
`else
    corr_d  = (s1_syn_q != '0);
    flip_en = corr_d;
`endif
    for (int p = 1; p <= N; p++) begin
      flip_mask[p-1] = flip_en && (s1_syn_q == R'(p));
    end
    data_d = extract(s1_code_q ^ flip_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      syn_q      <= '0;
      corr_q     <= 1'b0;
`ifdef HAMMING_SECDED_EN
      unc_q      <= 1'b0;
`endif
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q <= data_d;
        syn_q  <= s1_syn_q;
        corr_q <= corr_d;
`ifdef HAMMING_SECDED_EN
        unc_q  <= unc_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q <= '0;
`ifdef HAMMING_SECDED_EN
      cnt_unc_q  <= '0;
`endif
    end else if (clr_cnt) begin
      cnt_corr_q <= '0;
`ifdef HAMMING_SECDED_EN
      cnt_unc_q  <= '0;
`endif
    end else begin
      if (xfer && corr_q && (cnt_corr_q != '1)) cnt_corr_q <= cnt_corr_q + 1'b1;
`ifdef HAMMING_SECDED_EN
      if (xfer && unc_q && (cnt_unc_q != '1)) cnt_unc_q <= cnt_unc_q + 1'b1;
`endif
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_data      = data_q;
  assign out_syndrome  = syn_q;
  assign out_corrected = corr_q;
  assign cnt_corrected = cnt_corr_q;
`ifdef HAMMING_SECDED_EN
  assign out_uncorrectable = unc_q;
  assign cnt_uncorr        = cnt_unc_q;
`else
  assign out_uncorrectable = 1'b0;
  assign cnt_uncorr        = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Scoreboard bench for hamming_secded_dec: encoder/error-injection model feeds an expected queue, monitor checks outputs.
module tb_hamming_secded_dec;
  localparam int R     = 4;
  localparam int N     = 15;
  localparam int K     = 11;
  localparam int CNT_W = 2;
`ifdef HAMMING_SECDED_EN
  localparam int CW    = N + 1;
  localparam bit SECDED = 1'b1;
`else
  localparam int CW    = N;
  localparam bit SECDED = 1'b0;
`endif
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [K-1:0] data;
    logic [R-1:0] syn;
    logic         corr;
    logic         unc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CW-1:0]    in_code = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [K-1:0]     out_data;
  logic [R-1:0]     out_syndrome;
  logic             out_corrected;
  logic             out_uncorrectable;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_corrected;
  logic [CNT_W-1:0] cnt_uncorr;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   rnd_en = 1'b0;

  hamming_secded_dec #(.R(R), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable), .clr_cnt(clr_cnt),
    .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [K-1:0] data_of(input logic [N-1:0] c);
    logic [K-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // Place data, then set the parity bits whose weights cancel the data's syndrome.
  function automatic logic [CW-1:0] encode(input logic [K-1:0] d);
    logic [CW-1:0] c;
    int j;
    int s;
    c = '0;
    j = 0;
    s = 0;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int p = 1; p <= N; p++) if (c[p-1]) s = s ^ p;
    for (int b = 0; b < R; b++) if (s[b]) c[(1 << b) - 1] = 1'b1;
`ifdef HAMMING_SECDED_EN
    c[N] = ^c[N-1:0];
`endif
    return c;
  endfunction

  // e1/e2 are 1-based error positions (CW = overall bit when SECDED); 0 = none.
  task automatic mk(input logic [K-1:0] d, input int e1, input int e2,
                    output logic [CW-1:0] w, output exp_t e);
    int nerr;
    int syn;
    logic [N-1:0] fixed;
    w = encode(d);
    nerr = 0;
    syn = 0;
    if (e1 != 0) begin w[e1-1] = ~w[e1-1]; nerr++; if (e1 <= N) syn = syn ^ e1; end
    if (e2 != 0) begin w[e2-1] = ~w[e2-1]; nerr++; if (e2 <= N) syn = syn ^ e2; end
    e.syn  = R'(syn);
    e.data = d;
    e.corr = (nerr == 1);
    e.unc  = 1'b0;
    if (nerr == 2) begin
      if (SECDED) begin
        e.data = data_of(w[N-1:0]);
        e.unc  = 1'b1;
      end else begin
        fixed = w[N-1:0];
        fixed[syn-1] = ~fixed[syn-1];
        e.data = data_of(fixed);
        e.corr = 1'b1;
      end
    end
  endtask

  task automatic drive_word(input logic [CW-1:0] w, input exp_t e);
    int waitc;
    bit done;
    waitc = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_code = w;
    while (!done) begin
      if (rnd_en) begin
        out_ready = ($urandom_range(0, 3) != 0);
        clr_cnt   = ($urandom_range(0, 19) == 0);
      end
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end else if (++waitc > 100) begin
        failures++;
        $display("FAIL accept_timeout: in_ready stuck low, required 1");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [K-1:0] d, input int e1, input int e2);
    logic [CW-1:0] w;
    exp_t e;
    mk(d, e1, e2, w, e);
    drive_word(w, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_cnt = 1'b0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: counters vs model, stall stability, and scoreboard pops on each output transfer.
  int   m_cc = 0;
  int   m_cu = 0;
  bit   prev_stall = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_cc = 0;
      m_cu = 0;
      prev_stall = 1'b0;
    end else begin
      check("cnt_corrected", 32'(cnt_corrected), 32'(m_cc));
      check("cnt_uncorr", 32'(cnt_uncorr), 32'(m_cu));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'({out_data, out_syndrome, out_corrected, out_uncorrectable}), 32'(held));
      end
      e = '0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: data %0h with empty scoreboard", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
          check("out_corrected", 32'(out_corrected), 32'(e.corr));
          check("out_uncorrectable", 32'(out_uncorrectable), 32'(e.unc));
        end
      end
      if (clr_cnt) begin
        m_cc = 0;
        m_cu = 0;
      end else begin
        if (e.corr && m_cc < CMAX) m_cc++;
        if (e.unc && m_cu < CMAX) m_cu++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_data, out_syndrome, out_corrected, out_uncorrectable};
    end
  end

  initial begin
    int acc;
    logic [CW-1:0] bw[4];
    exp_t be[4];

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_syndrome", 32'(out_syndrome), 32'd0);
    check("rst_flags", 32'({out_corrected, out_uncorrectable}), 32'd0);
    check("rst_counters", 32'({cnt_corrected, cnt_uncorr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: one clean all-ones word, out_valid exactly two edges after acceptance.
    out_ready = 1'b1;
    send(11'h7FF, 0, 0);
    in_valid = 1'b0;
    check("latency_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_2", 32'(out_valid), 32'd1);
    drain();

    send(11'h7FF, 5, 0);
    send(11'h000, 1, 2);
    send(11'h000, CW, 0);
    send(11'h7FF, 7, 0);
    drain();

    for (int i = 0; i < 5; i++) send(K'($urandom), $urandom_range(1, CW), 0);
    drain();
    check("cnt_saturated", 32'(cnt_corrected), CMAX);

    // Clear coinciding with an error-word transfer.
    send(11'h123, 3, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check("clr_priority", 32'(cnt_corrected), 32'd0);
    drain();

    // Backpressure: only two words fit while the output is stalled.
    for (int i = 0; i < 4; i++) mk(K'($urandom), $urandom_range(0, CW), 0, bw[i], be[i]);
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code = bw[acc];
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(be[acc]);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = acc; i < 4; i++) drive_word(bw[i], be[i]);
    drain();

    // Randomised traffic with random stalls and occasional counter clears.
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int ne;
      int p1;
      int p2;
      ne = $urandom_range(0, 2);
      p1 = (ne >= 1) ? $urandom_range(1, CW) : 0;
      p2 = 0;
      if (ne == 2) begin
        p2 = $urandom_range(1, CW - 1);
        if (p2 >= p1) p2++;
      end
      send(K'($urandom), p1, p2);
      if ($urandom_range(0, 7) == 0) in_valid = 1'b0;
    end
    rnd_en = 1'b0;
    drain();

    // Reset with two words in flight.
    for (int i = 0; i < 3; i++) send(K'($urandom), $urandom_range(1, N), 0);
    drain();
    out_ready = 1'b0;
    send(K'($urandom), 4, 0);
    send(K'($urandom), 0, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_cnt", 32'(cnt_corrected), CMAX);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_counters", 32'({cnt_corrected, cnt_uncorr}), 32'd0);
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(11'h5A5, 9, 0);
    send(11'h0F0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
